reg_write_arbiter: RTL and testbench

- Shares the single register-bank write port (address/data/enable) between two requesters: the core writeback path and an auxiliary master (IO/serial/debug loader).
- Core has priority. Aux writes are buffered in a small FIFO and drained in idle slots.
- A starvation counter forces one aux write through when the core monopolises the port.
- Sits directly in front of the bank write port. Write outputs are registered, so the bank's negedge write lands in the same cycle they change.

---
 rtl/reg_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Arbitrates the register-bank write port between the core writeback path and a FIFO-buffered
// aux master. Core has priority; a starvation counter forces aux slots. Stats under ARB_STATS_EN.
module reg_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned AW           = 5,
  parameter int unsigned DW           = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       core_req,
  input  logic [AW-1:0]              core_addr,
  input  logic [DW-1:0]              core_data,
  output logic                       core_stall,
  input  logic                       aux_req,
  input  logic [AW-1:0]              aux_addr,
  input  logic [DW-1:0]              aux_data,
  output logic                       aux_ready,
  output logic                       aux_err,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic [DW-1:0]              wr_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]                aux_wr_cnt,
  output logic [15:0]                starve_cnt
`endif
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned AGW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {StNormal, StForce} state_e;

  state_e         state_q, state_d;
  logic [AGW-1:0] age_q, age_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [AW-1:0]  mem_addr_q [DEPTH];
  logic [DW-1:0]  mem_data_q [DEPTH];

  logic          aux_prot, push, pop, fifo_ne;
  logic          grant_core, grant_aux;
  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [DW-1:0] wr_data_d;

  // r0 plus the JR/AS/SP registers are never writable by the aux master.
  assign aux_prot = (aux_addr == '0) || (aux_addr == AW'(29)) ||
                    (aux_addr == AW'(30)) || (aux_addr == AW'(31));

  assign fifo_ne    = (count_q != '0);
  assign aux_ready  = (count_q != CW'(DEPTH));
  assign push       = aux_req & aux_ready & ~aux_prot;
  assign pop        = grant_aux;
  assign busy       = fifo_ne;
  assign fifo_count = count_q;
  assign core_stall = core_req & ~grant_core;

  always_comb begin
    grant_core = 1'b0;
    grant_aux  = 1'b0;
    state_d    = state_q;
    unique case (state_q)
      StNormal: begin
        if (core_req) grant_core = 1'b1;
        else if (fifo_ne) grant_aux = 1'b1;
      end
      StForce: begin
        grant_aux = fifo_ne;
        state_d   = StNormal;
      end
      default: state_d = StNormal;
    endcase

    age_d = age_q;
    if (pop || !fifo_ne) begin
      age_d = '0;
    end else if (state_q == StNormal && age_q == AGW'(STARVE_LIMIT)) begin
      age_d   = '0;
      state_d = StForce;
    end else begin
      age_d = age_q + AGW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A core write to r0 is consumed without a strobe; address/data hold when idle.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    if (grant_core) begin
      wr_en_d = (core_addr != '0);
      if (core_addr != '0) begin
        wr_addr_d = core_addr;
        wr_data_d = core_data;
      end
    end else if (grant_aux) begin
      wr_en_d   = 1'b1;
      wr_addr_d = mem_addr_q[rptr_q];
      wr_data_d = mem_data_q[rptr_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StNormal;
      age_q   <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      aux_err <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      aux_err <= aux_req & aux_prot;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wptr_q] <= aux_addr;
      mem_data_q[wptr_q] <= aux_data;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aux_wr_cnt <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant_aux && aux_wr_cnt != 16'hFFFF) aux_wr_cnt <= aux_wr_cnt + 16'd1;
      if (state_q == StForce && starve_cnt != 16'hFFFF) starve_cnt <= starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected bank writes are queued by the stimulus and
// popped by a monitor on every observed wr_en; status outputs are checked directly.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req;
  logic [4:0]  core_addr;
  logic [31:0] core_data;
  logic        core_stall;
  logic        aux_req;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        aux_err;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  fifo_count;
  logic        busy;
`ifdef ARB_STATS_EN
  logic [15:0] aux_wr_cnt;
  logic [15:0] starve_cnt;
`endif

  reg_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_data  (core_data),
    .core_stall (core_stall),
    .aux_req    (aux_req),
    .aux_addr   (aux_addr),
    .aux_data   (aux_data),
    .aux_ready  (aux_ready),
    .aux_err    (aux_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fifo_count (fifo_count),
`ifdef ARB_STATS_EN
    .aux_wr_cnt (aux_wr_cnt),
    .starve_cnt (starve_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe seen on the bank port must match the next queued write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_addr", {27'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.a});
          chk("wr_data", wr_data, e.d);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; core_req = 1'b0; core_addr = '0; core_data = '0;
    aux_req = 1'b0; aux_addr = '0; aux_data = '0;
    #2;
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_aux_err", {31'd0, aux_err}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();

    // Core only
    core_req = 1'b1; core_addr = 5'd5; core_data = 32'hA5;
    expect_wr(5'd5, 32'hA5);
    @(negedge clk);
    chk("core_only_stall", {31'd0, core_stall}, 0);
    tick();
    core_req = 1'b0;
    repeat (2) tick();

    // Aux only: no bypass, strobe two cycles after push
    aux_req = 1'b1; aux_addr = 5'd7; aux_data = 32'h1234;
    expect_wr(5'd7, 32'h1234);
    tick();
    aux_req = 1'b0;
    @(negedge clk);
    chk("aux_only_count1", {29'd0, fifo_count}, 1);
    chk("aux_only_no_bypass", {31'd0, wr_en}, 0);
    tick();
    @(negedge clk);
    chk("aux_only_wr_en", {31'd0, wr_en}, 1);
    chk("aux_only_count0", {29'd0, fifo_count}, 0);
    chk("aux_only_busy", {31'd0, busy}, 0);
    repeat (2) tick();

    // Fill while the core holds the port
    core_req = 1'b1; core_addr = 5'd3; core_data = 32'h33;
    for (int i = 1; i <= 5; i++) begin
      aux_req = 1'b1; aux_addr = 5'(i); aux_data = 32'h100 + i;
      expect_wr(5'd3, 32'h33);
      @(negedge clk);
      chk("fill_aux_ready", {31'd0, aux_ready}, (i < 5) ? 1 : 0);
      tick();
    end
    aux_req = 1'b0; core_req = 1'b0;
    for (int i = 1; i <= 4; i++) expect_wr(5'(i), 32'h100 + i);
    @(negedge clk);
    chk("fill_count", {29'd0, fifo_count}, 4);
    repeat (6) tick();
    chk("fill_drained", {29'd0, fifo_count}, 0);

    // Simultaneous push and pop keeps the count
    aux_req = 1'b1; aux_addr = 5'd10; aux_data = 32'hA0;
    expect_wr(5'd10, 32'hA0);
    tick();
    aux_addr = 5'd11; aux_data = 32'hB0;
    expect_wr(5'd11, 32'hB0);
    tick();
    aux_req = 1'b0;
    @(negedge clk);
    chk("push_pop_count", {29'd0, fifo_count}, 1);
    repeat (3) tick();

    // Starvation: head waits 8 cycles of age, then one forced slot
    core_req = 1'b1; core_addr = 5'd4; core_data = 32'h44;
    for (int k = 0; k <= 12; k++) begin
      aux_req = (k == 0); aux_addr = 5'd9; aux_data = 32'h99;
      if (k == 10) expect_wr(5'd9, 32'h99);
      else expect_wr(5'd4, 32'h44);
      @(negedge clk);
      chk($sformatf("starve_stall_%0d", k), {31'd0, core_stall}, (k == 10) ? 1 : 0);
      tick();
    end
    core_req = 1'b0; aux_req = 1'b0;
    repeat (2) tick();
`ifdef ARB_STATS_EN
    chk("starve_cnt", {16'd0, starve_cnt}, 1);
    chk("aux_wr_cnt", {16'd0, aux_wr_cnt}, 8);
`endif

    // Protected aux address and core write to r0
    aux_req = 1'b1; aux_addr = 5'd31; aux_data = 32'hDEAD;
    tick();
    aux_req = 1'b0;
    @(negedge clk);
    chk("prot_err_pulse", {31'd0, aux_err}, 1);
    chk("prot_count", {29'd0, fifo_count}, 0);
    tick();
    @(negedge clk);
    chk("prot_err_clear", {31'd0, aux_err}, 0);
    core_req = 1'b1; core_addr = 5'd0; core_data = 32'hBEEF;
    @(negedge clk);
    chk("r0_stall", {31'd0, core_stall}, 0);
    tick();
    core_req = 1'b0;
    @(negedge clk);
    chk("r0_no_wr_en", {31'd0, wr_en}, 0);
    repeat (2) tick();

    // Reset mid-operation discards queued entries
    core_req = 1'b1; core_addr = 5'd2; core_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      aux_req = 1'b1; aux_addr = 5'(12 + i); aux_data = 32'h200 + i;
      if (i < 2) expect_wr(5'd2, 32'h22);
      tick();
    end
    chk("pre_reset_count", {29'd0, fifo_count}, 3);
    reset = 1'b0; core_req = 1'b0; aux_req = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 0);
    chk("mid_rst_wr_addr", {27'd0, wr_addr}, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_count", {29'd0, fifo_count}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) tick();
    chk("post_reset_count", {29'd0, fifo_count}, 0);
    chk("pending_writes", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
